modexp_tx_core: RTL and testbench



---
 rtl/rsa_pkg.sv | 40 ++++
 rtl/modexp_tx_core_mont_mul.sv | 87 ++++++++
 rtl/modexp_tx_core.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_modexp_tx_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the Montgomery exponentiation / UART transmit core.
// Build option: MONEXP_TRACE_EN makes the engine log every MonPro result to TRACE_ADDR.
package rsa_pkg;

  localparam int unsigned BITLEN_DEF     = 16;
  localparam int unsigned LOG_BITLEN_DEF = 4;
  localparam int unsigned ABITS_DEF      = 8;
  localparam int unsigned DBITS_DEF      = 16;

  // Operand BRAM map
  localparam int unsigned X_BAR_ADDR  = 0;
  localparam int unsigned M_BAR_ADDR  = 1;
  localparam int unsigned TRACE_ADDR  = 4;
  localparam int unsigned RESULT_ADDR = 5;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_RD0,
    ENG_RD1,
    ENG_SQR,
    ENG_MUL,
    ENG_CONV,
    ENG_WB,
    ENG_DONE
  } eng_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT_HI,
    SER_WAIT_LO
  } ser_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_ITER,
    MM_RED
  } mm_state_e;

endpackage

// File: rtl/modexp_tx_core_mont_mul.sv
// Bit-serial radix-2 Montgomery product: one load cycle, k add/shift cycles, one reduce cycle.
// done_c/result_c are combinational during the reduce cycle.
module mont_mul
  import rsa_pkg::*;
#(
  parameter int unsigned BITLEN     = BITLEN_DEF,
  parameter int unsigned LOG_BITLEN = LOG_BITLEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITLEN-1:0]     x,
  input  logic [BITLEN-1:0]     y,
  input  logic [BITLEN-1:0]     n,
  input  logic [LOG_BITLEN:0]   k,
  output logic                  done_c,
  output logic [BITLEN-1:0]     result_c
);

  localparam int unsigned AW = BITLEN + 2;
  localparam int unsigned KW = LOG_BITLEN + 1;

  mm_state_e         state_q, state_d;
  logic [AW-1:0]     a_q, a_d;
  logic [BITLEN-1:0] x_q, x_d;
  logic [BITLEN-1:0] y_q, y_d;
  logic [BITLEN-1:0] n_q, n_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     sum_c;
  logic [AW-1:0]     adj_c;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    x_d      = x_q;
    y_d      = y_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    done_c   = 1'b0;
    sum_c    = a_q + (x_q[0] ? AW'(y_q) : AW'(0));
    adj_c    = sum_c + (sum_c[0] ? AW'(n_q) : AW'(0));
    result_c = (a_q >= AW'(n_q)) ? BITLEN'(a_q - AW'(n_q)) : BITLEN'(a_q);

    case (state_q)
      MM_IDLE: begin
        if (start) begin
          a_d     = '0;
          x_d     = x;
          y_d     = y;
          n_d     = n;
          cnt_d   = k;
          state_d = (k == '0) ? MM_RED : MM_ITER;
        end
      end
      MM_ITER: begin
        a_d   = adj_c >> 1;
        x_d   = x_q >> 1;
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) state_d = MM_RED;
      end
      MM_RED: begin
        done_c  = 1'b1;
        state_d = MM_IDLE;
      end
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MM_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/modexp_tx_core.sv
// Left-to-right Montgomery exponentiation over an operand BRAM, followed by an MSB-first
// byte serializer with a UART busy handshake. Build option: MONEXP_TRACE_EN (MonPro trace to BRAM).
module modexp_tx_core
  import rsa_pkg::*;
#(
  parameter int unsigned BITLEN     = BITLEN_DEF,
  parameter int unsigned LOG_BITLEN = LOG_BITLEN_DEF,
  parameter int unsigned ABITS      = ABITS_DEF,
  parameter int unsigned DBITS      = DBITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITLEN-1:0]     e,
  input  logic [LOG_BITLEN-1:0] e_idx,
  input  logic [BITLEN-1:0]     n,
  input  logic [LOG_BITLEN:0]   mp_count,
  input  logic [ABITS-1:0]      wr_addr,
  input  logic [DBITS-1:0]      wr_data,
  input  logic                  wr_en,
  input  logic                  is_transmitting,
  output logic                  stop,
  output logic [BITLEN-1:0]     ans,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid
);

  localparam int unsigned DEPTH  = 2 ** ABITS;
  localparam int unsigned NBYTES = BITLEN / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // ---------------- operand BRAM ----------------
  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] rd_data_q;
  logic [ABITS-1:0] rd_addr_c;
  logic             eng_we_c;
  logic [ABITS-1:0] eng_waddr_c;
  logic [DBITS-1:0] eng_wdata_c;

  // Engine write is issued last so it overrides a loader write to the same address
  always_ff @(posedge clk) begin
    if (wr_en)    mem_q[wr_addr]     <= wr_data;
    if (eng_we_c) mem_q[eng_waddr_c] <= eng_wdata_c;
    rd_data_q <= mem_q[rd_addr_c];
  end

  // ---------------- exponentiation engine ----------------
  eng_state_e            eng_q, eng_d;
  logic                  start_q, start_edge_q;
  logic [BITLEN-1:0]     e_q, e_d;
  logic [BITLEN-1:0]     n_q, n_d;
  logic [LOG_BITLEN:0]   k_q, k_d;
  logic [LOG_BITLEN-1:0] bit_q, bit_d;
  logic [BITLEN-1:0]     acc_q, acc_d;
  logic [BITLEN-1:0]     mbar_q, mbar_d;
  logic                  mbar_ld_q, mbar_ld_d;
  logic                  mm_start_q, mm_start_d;
  logic                  stop_q, stop_d;
  logic [BITLEN-1:0]     ans_q, ans_d;
  logic [BITLEN-1:0]     mm_y_c;
  logic                  mm_done_c;
  logic [BITLEN-1:0]     mm_result_c;

  mont_mul #(
    .BITLEN    (BITLEN),
    .LOG_BITLEN(LOG_BITLEN)
  ) u_mont_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mm_start_q),
    .x       (acc_q),
    .y       (mm_y_c),
    .n       (n_q),
    .k       (k_q),
    .done_c  (mm_done_c),
    .result_c(mm_result_c)
  );

  always_comb begin
    eng_d       = eng_q;
    e_d         = e_q;
    n_d         = n_q;
    k_d         = k_q;
    bit_d       = bit_q;
    acc_d       = acc_q;
    mbar_d      = mbar_q;
    mbar_ld_d   = 1'b0;
    mm_start_d  = 1'b0;
    stop_d      = 1'b0;
    ans_d       = ans_q;
    rd_addr_c   = ABITS'(M_BAR_ADDR);
    mm_y_c      = acc_q;
    eng_we_c    = 1'b0;
    eng_waddr_c = ABITS'(RESULT_ADDR);
    eng_wdata_c = DBITS'(acc_q);

    // M_bar arrives one cycle after RD1 issues its address
    if (mbar_ld_q) mbar_d = BITLEN'(rd_data_q);

    case (eng_q)
      ENG_IDLE: begin
        if (start_edge_q) begin
          e_d   = e;
          n_d   = n;
          k_d   = mp_count;
          bit_d = e_idx;
          if (mp_count == '0) begin
            acc_d = '0;
            eng_d = ENG_DONE;
          end else begin
            eng_d = ENG_RD0;
          end
        end
      end
      ENG_RD0: begin
        rd_addr_c = ABITS'(X_BAR_ADDR);
        eng_d     = ENG_RD1;
      end
      ENG_RD1: begin
        acc_d      = BITLEN'(rd_data_q);
        mbar_ld_d  = 1'b1;
        mm_start_d = 1'b1;
        eng_d      = ENG_SQR;
      end
      ENG_SQR: begin
        if (mm_done_c) begin
          acc_d      = mm_result_c;
          mm_start_d = 1'b1;
          if (e_q[bit_q]) begin
            eng_d = ENG_MUL;
          end else if (bit_q == '0) begin
            eng_d = ENG_CONV;
          end else begin
            bit_d = bit_q - LOG_BITLEN'(1);
            eng_d = ENG_SQR;
          end
        end
      end
      ENG_MUL: begin
        mm_y_c = mbar_q;
        if (mm_done_c) begin
          acc_d      = mm_result_c;
          mm_start_d = 1'b1;
          if (bit_q == '0) begin
            eng_d = ENG_CONV;
          end else begin
            bit_d = bit_q - LOG_BITLEN'(1);
            eng_d = ENG_SQR;
          end
        end
      end
      ENG_CONV: begin
        mm_y_c = BITLEN'(1);
        if (mm_done_c) begin
          acc_d = mm_result_c;
          eng_d = ENG_WB;
        end
      end
      ENG_WB: begin
        eng_we_c = 1'b1;
        eng_d    = ENG_DONE;
      end
      ENG_DONE: begin
        stop_d = 1'b1;
        ans_d  = acc_q;
        eng_d  = ENG_IDLE;
      end
      default: eng_d = ENG_IDLE;
    endcase

`ifdef MONEXP_TRACE_EN
    if (mm_done_c) begin
      eng_we_c    = 1'b1;
      eng_waddr_c = ABITS'(TRACE_ADDR);
      eng_wdata_c = DBITS'(mm_result_c);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_q        <= ENG_IDLE;
      start_q      <= 1'b0;
      start_edge_q <= 1'b0;
      e_q          <= '0;
      n_q          <= '0;
      k_q          <= '0;
      bit_q        <= '0;
      acc_q        <= '0;
      mbar_q       <= '0;
      mbar_ld_q    <= 1'b0;
      mm_start_q   <= 1'b0;
      stop_q       <= 1'b0;
      ans_q        <= '0;
    end else begin
      eng_q        <= eng_d;
      start_q      <= start;
      start_edge_q <= start & ~start_q;
      e_q          <= e_d;
      n_q          <= n_d;
      k_q          <= k_d;
      bit_q        <= bit_d;
      acc_q        <= acc_d;
      mbar_q       <= mbar_d;
      mbar_ld_q    <= mbar_ld_d;
      mm_start_q   <= mm_start_d;
      stop_q       <= stop_d;
      ans_q        <= ans_d;
    end
  end

  // ---------------- byte serializer ----------------
  ser_state_e        ser_q, ser_d;
  logic [BITLEN-1:0] sh_q, sh_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  // Loads alongside the stop pulse so the first byte can go out the cycle after stop
  always_comb begin
    ser_d      = ser_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;

    if (stop_d) begin
      sh_d   = acc_q;
      bcnt_d = BCW'(NBYTES - 1);
      ser_d  = SER_SEND;
    end else begin
      case (ser_q)
        SER_IDLE: ser_d = SER_IDLE;
        SER_SEND: begin
          if (!is_transmitting) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = sh_q[BITLEN-1 -: 8];
            ser_d      = SER_WAIT_HI;
          end
        end
        SER_WAIT_HI: begin
          if (is_transmitting) ser_d = SER_WAIT_LO;
        end
        SER_WAIT_LO: begin
          if (!is_transmitting) begin
            if (bcnt_q == '0) begin
              ser_d = SER_IDLE;
            end else begin
              bcnt_d = bcnt_q - BCW'(1);
              sh_d   = sh_q << 8;
              ser_d  = SER_SEND;
            end
          end
        end
        default: ser_d = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_q      <= SER_IDLE;
      sh_q       <= '0;
      bcnt_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      ser_q      <= ser_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign stop     = stop_q;
  assign ans      = ans_q;
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_modexp_tx_core.sv
// Self-checking bench for modexp_tx_core: directed vectors plus randomized operands
// checked against plain modular arithmetic.
module tb_modexp_tx_core;

  localparam int unsigned BITLEN     = 16;
  localparam int unsigned LOG_BITLEN = 4;
  localparam int unsigned ABITS      = 8;
  localparam int unsigned DBITS      = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [BITLEN-1:0]     e_in;
  logic [LOG_BITLEN-1:0] eidx_in;
  logic [BITLEN-1:0]     n_in;
  logic [LOG_BITLEN:0]   k_in;
  logic [ABITS-1:0]      wr_addr;
  logic [DBITS-1:0]      wr_data;
  logic                  wr_en;
  logic                  is_tx;
  logic                  stop;
  logic [BITLEN-1:0]     ans;
  logic [7:0]            tx_byte;
  logic                  tx_valid;

  int checks   = 0;
  int failures = 0;

  modexp_tx_core #(
    .BITLEN    (BITLEN),
    .LOG_BITLEN(LOG_BITLEN),
    .ABITS     (ABITS),
    .DBITS     (DBITS)
  ) dut (
    .clk            (clk),
    .rst            (rst_n),
    .start          (start),
    .e              (e_in),
    .e_idx          (eidx_in),
    .n              (n_in),
    .mp_count       (k_in),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .is_transmitting(is_tx),
    .stop           (stop),
    .ans            (ans),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Right-to-left binary exponentiation with ordinary modular arithmetic
  function automatic longint unsigned pow_mod(input longint unsigned b, input longint unsigned x,
                                              input longint unsigned m);
    longint unsigned r  = 1 % m;
    longint unsigned bb = b % m;
    longint unsigned xx = x;
    while (xx != 0) begin
      if (xx[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      xx = xx >> 1;
    end
    return r;
  endfunction

  function automatic int popcnt(input int unsigned v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic launch(input int unsigned m, input int unsigned ev, input int unsigned eidx,
                        input int unsigned nv, input int unsigned kv);
    longint unsigned r_pow;
    r_pow   = 64'd1 << kv;
    wr_en   = 1'b1;
    wr_addr = 8'd0;
    wr_data = 16'(r_pow % nv);
    step();
    wr_addr = 8'd1;
    wr_data = 16'((longint'(m) * r_pow) % nv);
    step();
    wr_en   = 1'b0;
    e_in    = 16'(ev);
    eidx_in = 4'(eidx);
    n_in    = 16'(nv);
    k_in    = 5'(kv);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Runs one exponentiation; with coll set, the loader hits RESULT_ADDR in the write-back cycle
  task automatic run_exp(input int unsigned m, input int unsigned ev, input int unsigned eidx,
                         input int unsigned nv, input int unsigned kv, input bit coll);
    longint unsigned expv;
    int unsigned     ee;
    int              lat;
    int              c;
    bit              got;
    ee   = ev & ((32'd1 << (eidx + 1)) - 32'd1);
    expv = (kv == 0) ? 64'd0 : pow_mod(longint'(m), longint'(ee), longint'(nv));
    lat  = 3 + (int'(eidx) + 1 + popcnt(ee) + 1) * (int'(kv) + 2) + 2;
    launch(m, ev, eidx, nv, kv);
    c   = 0;
    got = 1'b0;
    while (!got && c < lat + 20) begin
      if (coll && c == lat - 2) begin
        wr_en   = 1'b1;
        wr_addr = 8'd5;
        wr_data = 16'hBEEF;
      end else if (c == lat - 1) begin
        wr_en = 1'b0;
      end
      step();
      c++;
      if (stop) got = 1'b1;
    end
    wr_en = 1'b0;
    check("stop_seen", 32'(got), 32'd1);
    if (kv != 0) check("stop_latency", c, lat);
    check("ans", 32'(ans), 32'(expv));
    if (kv != 0) check("result_addr5", 32'(dut.mem_q[5]), 32'(expv));
    step();
    check("stop_one_cycle", 32'(stop), 32'd0);
    check("tx_valid_first", 32'(tx_valid), 32'd1);
    check("tx_byte_msb", 32'(tx_byte), 32'((expv >> 8) & 64'hFF));
  endtask

  initial begin
    int  c;
    bit  seen;
    bit  got;
    int unsigned kv, nv, mv, ev, eidx;

    rst_n   = 1'b0;
    start   = 1'b0;
    e_in    = '0;
    eidx_in = '0;
    n_in    = '0;
    k_in    = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    is_tx   = 1'b0;
    step();
    step();
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_ans", 32'(ans), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // 2^3 mod 589 with the full UART handshake on both bytes
    run_exp(2, 3, 1, 589, 10, 1'b0);
    check("vec_e3_ans", 32'(ans), 32'd8);
    is_tx = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      step();
      if (tx_valid) seen = 1'b1;
    end
    check("no_tx_while_busy", 32'(seen), 32'd0);
    is_tx = 1'b0;
    c     = 0;
    got   = 1'b0;
    while (!got && c < 10) begin
      step();
      c++;
      if (tx_valid) got = 1'b1;
    end
    check("second_tx_valid", 32'(got), 32'd1);
    check("second_tx_timing", c, 2);
    check("second_byte", 32'(tx_byte), 32'h08);
    is_tx = 1'b1;
    repeat (3) step();
    is_tx = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      step();
      if (tx_valid) seen = 1'b1;
    end
    check("no_third_byte", 32'(seen), 32'd0);
    check("tx_byte_held", 32'(tx_byte), 32'h08);
    check("ans_held", 32'(ans), 32'd8);

    // Reset in the middle of a computation, then a clean rerun
    launch(2, 5, 2, 589, 10);
    repeat (25) step();
    rst_n = 1'b0;
    #1;
    check("midrst_stop", 32'(stop), 32'd0);
    check("midrst_ans", 32'(ans), 32'd0);
    check("midrst_tx_byte", 32'(tx_byte), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (150) begin
      step();
      if (stop) seen = 1'b1;
    end
    check("no_stop_after_rst", 32'(seen), 32'd0);

    run_exp(2, 5, 2, 589, 10, 1'b0);
    check("vec_e5_ans", 32'(ans), 32'd32);
    run_exp(2, 0, 0, 589, 10, 1'b0);
    check("vec_e0_ans", 32'(ans), 32'd1);
    run_exp(2, 3, 1, 589, 10, 1'b1);
    check("collision_addr5", 32'(dut.mem_q[5]), 32'd8);
    run_exp(2, 3, 1, 589, 0, 1'b0);
    check("k0_ans", 32'(ans), 32'd0);

    for (int it = 0; it < 8; it++) begin
      kv   = $urandom_range(16, 2);
      nv   = $urandom_range((32'd1 << kv) - 32'd1, 3) | 32'd1;
      mv   = $urandom_range(nv - 1, 0);
      ev   = $urandom & 32'hFFFF;
      eidx = $urandom_range(15, 0);
      run_exp(mv, ev, eidx, nv, kv, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
